// File: rtl/downmixer_ctrl.sv
// -----------------------------------------------------------------------------
// downmixer_ctrl
//
// Sequences a downmixer capture run. The control flow is IDLE -> WARMUP -> RUN.
// A clock divider produces one sample strobe every DIV clocks. The first
// SETTLE strobes of a run are only counted. Each strobe seen in RUN captures
// I_in/Q_in into a small FIFO exactly CAP_DLY clocks later. The FIFO drains
// through a valid/ready stream.
//
// Ports
//   clk          system clock (1.6 MHz nominal)
//   rst          asynchronous reset, active low
//   start, stop  single-cycle run requests (stop wins when both are high)
//   mix_en       downmixer enable, high in WARMUP and RUN
//   sample_stb   one-cycle ADC/mixer sample strobe
//   I_in, Q_in   signed downmixer outputs
//   iq_valid     FIFO not empty
//   iq_ready     downstream accept
//   iq_i, iq_q   FIFO head entry
//   busy         state is not IDLE
//   ovf          sticky overflow flag; cleared by reset or an accepted start
//   sample_cnt   saturating count of samples written in the current run
//
// Parameter assumptions: DEPTH is a power of two >= 2, 1 <= CAP_DLY < DIV,
// and SETTLE >= 1.
// -----------------------------------------------------------------------------
module downmixer_ctrl #(
    parameter int NOUT    = 16,
    parameter int DIV     = 20,
    parameter int SETTLE  = 64,
    parameter int CAP_DLY = 2,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   mix_en,
    output logic                   sample_stb,
    input  logic signed [NOUT-1:0] I_in,
    input  logic signed [NOUT-1:0] Q_in,
    output logic                   iq_valid,
    input  logic                   iq_ready,
    output logic signed [NOUT-1:0] iq_i,
    output logic signed [NOUT-1:0] iq_q,
    output logic                   busy,
    output logic                   ovf,
    output logic [15:0]            sample_cnt
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CAP_W = $clog2(CAP_DLY + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = 2 * NOUT;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    state_t             state_reg;
    logic               mix_en_reg;
    logic               busy_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [SET_W-1:0]   settle_reg;
    logic               pend_reg;
    logic [CAP_W-1:0]   cap_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [OCC_W-1:0]   occ_reg;
    logic               ovf_reg;
    logic [15:0]        cnt_reg;
    logic [ENT_W-1:0]   head_reg;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic               active;
    logic               stb;
    logic               start_ok;
    logic               stop_ok;
    logic               pop;
    logic               full;
    logic               wr_req;
    logic               wr_en;
    logic [ENT_W-1:0]   wr_data;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [OCC_W-1:0]   occ_next;
    logic [ENT_W-1:0]   head_next;

    assign active      = (state_reg != IDLE);
    assign stb         = active && (div_reg == DIV_W'(DIV - 1));
    assign start_ok    = (state_reg == IDLE) && start && !stop;
    assign stop_ok     = active && stop;
    assign pop         = (occ_reg != '0) && iq_ready;
    assign full        = (occ_reg == OCC_W'(DEPTH));
    // The capture fires only while still in RUN. A stop that lands before
    // the capture cycle has already returned the block to IDLE.
    assign wr_req      = pend_reg && (cap_reg == CAP_W'(CAP_DLY)) && (state_reg == RUN);
    // When the FIFO is full, a pop in the same cycle frees the slot being written.
    assign wr_en       = wr_req && (!full || pop);
    assign wr_data     = {I_in, Q_in};
    assign rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    assign occ_next    = occ_reg + OCC_W'(wr_en) - OCC_W'(pop);

    // The head register is the registered read port of the FIFO memory.
    // If the entry being written becomes the head at once, it bypasses the
    // array, because the memory does not hold it yet.
    always_comb begin
        head_next = mem[rd_ptr_next];
        if (wr_en && ((occ_reg - OCC_W'(pop)) == '0)) begin
            head_next = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            mix_en_reg <= 1'b0;
            busy_reg   <= 1'b0;
            div_reg    <= '0;
            settle_reg <= '0;
            pend_reg   <= 1'b0;
            cap_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            ovf_reg    <= 1'b0;
            cnt_reg    <= '0;
            head_reg   <= '0;
        end else begin
            // Run control
            if (start_ok) begin
                state_reg  <= WARMUP;
                mix_en_reg <= 1'b1;
                busy_reg   <= 1'b1;
                div_reg    <= '0;
                settle_reg <= '0;
                pend_reg   <= 1'b0;
                cap_reg    <= '0;
            end else if (stop_ok) begin
                state_reg  <= IDLE;
                mix_en_reg <= 1'b0;
                busy_reg   <= 1'b0;
                div_reg    <= '0;
                settle_reg <= '0;
                pend_reg   <= 1'b0;
                cap_reg    <= '0;
            end else if (active) begin
                div_reg <= stb ? '0 : div_reg + DIV_W'(1);
                if (stb && (state_reg == WARMUP)) begin
                    settle_reg <= settle_reg + SET_W'(1);
                    if (settle_reg == SET_W'(SETTLE - 1)) begin
                        state_reg <= RUN;
                    end
                end
                // cap_reg counts the clocks elapsed since the arming strobe.
                if (stb && (state_reg == RUN)) begin
                    pend_reg <= 1'b1;
                    cap_reg  <= CAP_W'(1);
                end else if (wr_req) begin
                    pend_reg <= 1'b0;
                end else if (pend_reg) begin
                    cap_reg <= cap_reg + CAP_W'(1);
                end
            end

            // FIFO; an accepted start discards any remaining contents
            if (start_ok) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                occ_reg    <= '0;
                ovf_reg    <= 1'b0;
                cnt_reg    <= '0;
            end else begin
                rd_ptr_reg <= rd_ptr_next;
                occ_reg    <= occ_next;
                if (wr_en) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (cnt_reg != 16'hFFFF) begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end else if (wr_req) begin
                    ovf_reg <= 1'b1;
                end
                if ((wr_en || pop) && (occ_next != '0)) begin
                    head_reg <= head_next;
                end
            end
        end
    end

    assign mix_en     = mix_en_reg;
    assign busy       = busy_reg;
    assign sample_stb = stb;
    assign iq_valid   = (occ_reg != '0);
    assign iq_i       = head_reg[ENT_W-1:NOUT];
    assign iq_q       = head_reg[NOUT-1:0];
    assign ovf        = ovf_reg;
    assign sample_cnt = cnt_reg;

endmodule

// File: doc/downmixer_ctrl.md
DOWNMIXER_CTRL -- requirements
Module: downmixer_ctrl

Interface
REQ-001 Parameters: NOUT, default 16, I/Q sample width; DIV, default 20, clk cycles per sample (1.6 MHz -> 80 kHz); SETTLE, default 64, samples discarded after enable; CAP_DLY, default 2, clk cycles from strobe to I/Q capture; DEPTH, default 4, FIFO entries (power of 2).
REQ-002 clk  in  1  system clock, 1.6 MHz nominal.
REQ-003 rst  in  1  asynchronous reset, active-low.
REQ-004 start  in  1  single-cycle request to begin a capture run.
REQ-005 stop  in  1  single-cycle request to end a run.
REQ-006 mix_en  out  1  enable to downmixer.
REQ-007 sample_stb  out  1  one-cycle ADC/mixer sample strobe.
REQ-008 I_in, Q_in  in  NOUT each  signed downmixer outputs.
REQ-009 iq_valid  out  1; iq_ready  in  1; iq_i, iq_q  out  NOUT each  downstream sample stream.
REQ-010 busy  out  1  state != IDLE.
REQ-011 ovf  out  1  sticky FIFO overflow flag.
REQ-012 sample_cnt  out  16  samples written to FIFO in current run.

Function
REQ-013 FSM states IDLE, WARMUP, RUN; held in IDLE while rst low.
REQ-014 IDLE -> WARMUP on start=1 and stop=0; start clears FIFO, ovf, sample_cnt, divider and settle counter in the same edge.
REQ-015 WARMUP -> RUN on the edge after the SETTLE-th sample_stb of the run.
REQ-016 WARMUP or RUN -> IDLE on stop=1; stop wins over start when simultaneous; start ignored outside IDLE.
REQ-017 mix_en = 1 exactly in WARMUP and RUN (registered, follows state).
REQ-018 Divider counts 0..DIV-1 in WARMUP/RUN, wraps to 0, held at 0 in IDLE; sample_stb = 1 for the cycle divider == DIV-1, never in IDLE.
REQ-019 Strobes in WARMUP counted only, never captured.
REQ-020 Strobe in RUN arms a capture; I_in/Q_in written to FIFO exactly CAP_DLY cycles after the strobe cycle; stop or reset before that cancels the pending capture.
REQ-021 CAP_DLY < DIV; at most one pending capture.
REQ-022 FIFO DEPTH entries of {I,Q}; iq_valid = FIFO not empty; pop when iq_valid and iq_ready; iq_i/iq_q show head entry, stable while iq_valid and not iq_ready.
REQ-023 Write and pop in same cycle when full: both succeed, occupancy unchanged, no overflow.
REQ-024 Write when full without pop: sample dropped, ovf set, sample_cnt not incremented; ovf cleared only by reset or accepted start.
REQ-025 sample_cnt increments per successful write, saturates at 16'hFFFF.
REQ-026 FIFO contents remain drainable in IDLE after stop; no new writes in IDLE.
REQ-027 Pointers wrap modulo DEPTH; occupancy counter range 0..DEPTH.

Reset
REQ-028 rst low asynchronously forces: state IDLE, mix_en 0, sample_stb 0, iq_valid 0, iq_i/iq_q 0, busy 0, ovf 0, sample_cnt 0, FIFO empty, all counters 0, pending capture cleared.
REQ-029 Reset asserted mid-run takes effect without waiting for a clk edge; block restarts only on a new start.

Verification (DIV=20, SETTLE=4, CAP_DLY=2, DEPTH=4; start pulse at cycle 0)
REQ-030 Nominal: iq_ready=1, I_in=16'h0123, Q_in=16'hFEDC -> busy/mix_en high from cycle 1; strobes at cycles 20,40,60,80,100; RUN from 81; first write cycle 102; iq_valid cycle 103 with iq_i=16'h0123, iq_q=16'hFEDC; sample_cnt=1.
REQ-031 Backpressure: iq_ready=0 for 6 RUN samples -> 4 stored, ovf=1 after 5th, sample_cnt=4; raising iq_ready drains the first 4 in order.
REQ-032 Full + simultaneous pop at write cycle -> occupancy stays 4, ovf stays 0.
REQ-033 stop at cycle 101 (pending capture) -> IDLE at 102, mix_en 0, no write at 102, sample_stb silent thereafter.
REQ-034 start and stop both high in IDLE -> remains IDLE, mix_en 0; rst low at cycle 50 -> all outputs zero immediately, no strobe at 60.
